frogger_round_ctrl: RTL and testbench

Game-flow controller for the Frogger board. It sequences rounds (idle, play, hit, clear, game over, won) and generates the car-advance tick whose period shortens per level. It issues the round-reset pulse to the frog/car cell arrays and the input-freeze flag to the user-input blocks. It sits between checkFrog (crash/survive detection) and the car/frog cell arrays, replacing the free-running fixed 1.5 s car-enable counter.

---
 rtl/frogger_round_ctrl_if.sv | 26 ++
 rtl/frogger_round_ctrl.sv | 167 ++++++++++++++++
 tb/tb_frogger_round_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frogger_round_ctrl_if.sv
// Signal bundle between the round controller and the rest of the Frogger board:
// crash/survive detection and the start key in; tick, reload and status out.
interface frogger_round_ctrl_if;
    logic       start;
    logic       crashed;
    logic       survived;
    logic       car_tick;
    logic       round_reset;
    logic       need_reset;
    logic [3:0] level;
    logic [1:0] lives;
    logic [2:0] state;
    logic       game_over;

    // Controller side: consumes the game events and drives the status outputs.
    modport master (
        input  start, crashed, survived,
        output car_tick, round_reset, need_reset, level, lives, state, game_over
    );

    // Board side: produces the game events and consumes the status outputs.
    modport slave (
        output start, crashed, survived,
        input  car_tick, round_reset, need_reset, level, lives, state, game_over
    );
endinterface

// File: rtl/frogger_round_ctrl.sv
// Frogger game-flow controller: sequences rounds, generates the car-advance tick
// whose period shrinks with the level, and issues round reloads / input freeze.
module frogger_round_ctrl #(
    parameter int unsigned BASE_PERIOD  = 75000000,
    parameter int unsigned PERIOD_STEP  = 7500000,
    parameter int unsigned MIN_PERIOD   = 15000000,
    parameter int unsigned MAX_LEVEL    = 9,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned PAUSE_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    frogger_round_ctrl_if.master  bus
);

    localparam int CNT_W   = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
    localparam int PAUSE_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [3:0]         LVL_MAX    = 4'(MAX_LEVEL);
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_HIT   = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4,
        ST_WON   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         level_q, level_d;
    logic [1:0]         lives_q, lives_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [PAUSE_W-1:0] pause_cnt_q, pause_cnt_d;
    logic               car_tick_q, car_tick_d;
    logic               round_reset_q, round_reset_d;
    logic               need_reset_q, need_reset_d;
    logic               game_over_q, game_over_d;

    logic [31:0]        step_total;
    logic [31:0]        period;

    // Tick period for the current level, saturating at the floor instead of underflowing.
    always_comb begin
        step_total = 32'(level_q) * PERIOD_STEP;
        if (BASE_PERIOD >= MIN_PERIOD + step_total) begin
            period = BASE_PERIOD - step_total;
        end else begin
            period = MIN_PERIOD;
        end
    end

    // Next-state, counters and registered-output values for the round sequencer.
    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        lives_d       = lives_q;
        tick_cnt_d    = tick_cnt_q;
        pause_cnt_d   = pause_cnt_q;
        round_reset_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = ST_PLAY;
                    round_reset_d = 1'b1;
                    tick_cnt_d    = '0;
                end
            end
            ST_PLAY: begin
                // A crash beats a simultaneous survive: the frog died on the last row.
                if (bus.crashed) begin
                    state_d     = ST_HIT;
                    lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    pause_cnt_d = '0;
                end else if (bus.survived) begin
                    state_d     = ST_CLEAR;
                    level_d     = (level_q == LVL_MAX) ? LVL_MAX : level_q + 4'd1;
                    pause_cnt_d = '0;
                end else if (32'(tick_cnt_q) == period - 32'd1) begin
                    tick_cnt_d = '0;
                end else begin
                    tick_cnt_d = tick_cnt_q + CNT_W'(1);
                end
            end
            ST_HIT: begin
                if (pause_cnt_q == PAUSE_LAST) begin
                    if (lives_q == 2'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d       = ST_PLAY;
                        round_reset_d = 1'b1;
                        tick_cnt_d    = '0;
                    end
                end else begin
                    pause_cnt_d = pause_cnt_q + PAUSE_W'(1);
                end
            end
            ST_CLEAR: begin
                if (pause_cnt_q == PAUSE_LAST) begin
                    if (level_q == LVL_MAX) begin
                        state_d = ST_WON;
                    end else begin
                        state_d       = ST_PLAY;
                        round_reset_d = 1'b1;
                        tick_cnt_d    = '0;
                    end
                end else begin
                    pause_cnt_d = pause_cnt_q + PAUSE_W'(1);
                end
            end
            ST_OVER, ST_WON: begin
                if (bus.start) begin
                    state_d       = ST_PLAY;
                    level_d       = 4'd0;
                    lives_d       = LIVES_INIT;
                    round_reset_d = 1'b1;
                    tick_cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The tick is registered, so it is raised on the edge the counter reaches period-1.
        car_tick_d   = (state_q == ST_PLAY) && (state_d == ST_PLAY) &&
                       (32'(tick_cnt_d) == period - 32'd1);
        need_reset_d = (state_d != ST_PLAY);
        game_over_d  = (state_d == ST_OVER) || (state_d == ST_WON);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            level_q       <= 4'd0;
            lives_q       <= LIVES_INIT;
            tick_cnt_q    <= '0;
            pause_cnt_q   <= '0;
            car_tick_q    <= 1'b0;
            round_reset_q <= 1'b0;
            need_reset_q  <= 1'b1;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            tick_cnt_q    <= tick_cnt_d;
            pause_cnt_q   <= pause_cnt_d;
            car_tick_q    <= car_tick_d;
            round_reset_q <= round_reset_d;
            need_reset_q  <= need_reset_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.car_tick    = car_tick_q;
    assign bus.round_reset = round_reset_q;
    assign bus.need_reset  = need_reset_q;
    assign bus.level       = level_q;
    assign bus.lives       = lives_q;
    assign bus.state       = state_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_frogger_round_ctrl.sv
// Directed bench for frogger_round_ctrl. Two instances share one stimulus stream:
// dut_a uses MIN_PERIOD=4, dut_b uses MIN_PERIOD=7 so the period floor shows at level 2.
module tb_frogger_round_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    frogger_round_ctrl_if bus_a();
    frogger_round_ctrl_if bus_b();

    assign bus_b.start    = bus_a.start;
    assign bus_b.crashed  = bus_a.crashed;
    assign bus_b.survived = bus_a.survived;

    frogger_round_ctrl #(
        .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(4),
        .MAX_LEVEL(3), .LIVES(2), .PAUSE_CYCLES(5)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    frogger_round_ctrl #(
        .BASE_PERIOD(10), .PERIOD_STEP(2), .MIN_PERIOD(7),
        .MAX_LEVEL(3), .LIVES(2), .PAUSE_CYCLES(5)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp observed pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
    endtask

    task automatic pulse_survive();
        bus_a.survived = 1'b1;
        step();
        bus_a.survived = 0;
    endtask

    task automatic pulse_crash();
        bus_a.crashed = 1'b1;
        step();
        bus_a.crashed = 1'b0;
    endtask

    // Run ncyc cycles, recording the first two tick times of each DUT relative to base.
    task automatic measure(input int base, input int ncyc,
                           output int a1, output int a2, output int na,
                           output int b1, output int b2, output int nb);
        a1 = -1; a2 = -1; na = 0;
        b1 = -1; b2 = -1; nb = 0;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (bus_a.car_tick) begin
                na++;
                if (a1 < 0) a1 = cyc - base;
                else if (a2 < 0) a2 = cyc - base;
            end
            if (bus_b.car_tick) begin
                nb++;
                if (b1 < 0) b1 = cyc - base;
                else if (b2 < 0) b2 = cyc - base;
            end
        end
    endtask

    initial begin
        int r, e, a1, a2, na, b1, b2, nb;

        reset          = 1'b1;
        bus_a.start    = 1'b0;
        bus_a.crashed  = 1'b0;
        bus_a.survived = 1'b0;
        repeat (3) step();

        // Reset values
        check_eq("rst_state", int'(bus_a.state), 0);
        check_eq("rst_need_reset", int'(bus_a.need_reset), 1);
        reset = 1'b0;
        step();
        check_eq("idle_state", int'(bus_a.state), 0);
        check_eq("idle_level", int'(bus_a.level), 0);
        check_eq("idle_lives", int'(bus_a.lives), 2);
        check_eq("idle_car_tick", int'(bus_a.car_tick), 0);
        check_eq("idle_round_reset", int'(bus_a.round_reset), 0);
        check_eq("idle_need_reset", int'(bus_a.need_reset), 1);
        check_eq("idle_game_over", int'(bus_a.game_over), 0);
        measure(cyc, 12, a1, a2, na, b1, b2, nb);
        check_eq("idle_no_ticks", na, 0);
        check_eq("idle_stays", int'(bus_a.state), 0);
        $display("[TB] reset/idle checked at cycle %0d", cyc);

        // 1: start -> PLAY, single round_reset, ticks at +9, +19, +29 after it
        pulse_start();
        r = cyc;
        check_eq("t1_state", int'(bus_a.state), 1);
        check_eq("t1_round_reset", int'(bus_a.round_reset), 1);
        check_eq("t1_need_reset", int'(bus_a.need_reset), 0);
        step();
        check_eq("t1_round_reset_drop", int'(bus_a.round_reset), 0);
        measure(r, 30, a1, a2, na, b1, b2, nb);
        check_eq("t1_first_tick", a1, 9);
        check_eq("t1_spacing", a2 - a1, 10);
        check_eq("t1_tick_count", na, 3);
        check_eq("t1_b_first_tick", b1, 9);
        $display("[TB] start: play entry at %0d first tick +%0d spacing %0d", r, a1, a2 - a1);

        // 2: survive -> CLEAR for 5 cycles, then PLAY at level 1 with period 8
        pulse_survive();
        e = cyc;
        check_eq("t2_state_clear", int'(bus_a.state), 3);
        check_eq("t2_level", int'(bus_a.level), 1);
        check_eq("t2_need_reset", int'(bus_a.need_reset), 1);
        measure(e, 4, a1, a2, na, b1, b2, nb);
        check_eq("t2_pause_no_ticks", na + nb, 0);
        check_eq("t2_still_clear", int'(bus_a.state), 3);
        step();
        r = cyc;
        check_eq("t2_state_play", int'(bus_a.state), 1);
        check_eq("t2_round_reset", int'(bus_a.round_reset), 1);
        measure(r, 20, a1, a2, na, b1, b2, nb);
        check_eq("t2_first_tick", a1, 7);
        check_eq("t2_spacing", a2 - a1, 8);
        $display("[TB] survive: level 1 first tick +%0d spacing %0d", a1, a2 - a1);

        // 3: crashed and survived together -> HIT, crash wins
        bus_a.crashed  = 1'b1;
        bus_a.survived = 1'b1;
        step();
        bus_a.crashed  = 1'b0;
        bus_a.survived = 1'b0;
        check_eq("t3_state_hit", int'(bus_a.state), 2);
        check_eq("t3_lives", int'(bus_a.lives), 1);
        check_eq("t3_level", int'(bus_a.level), 1);
        repeat (4) step();
        check_eq("t3_still_hit", int'(bus_a.state), 2);
        step();
        check_eq("t3_state_play", int'(bus_a.state), 1);
        check_eq("t3_round_reset", int'(bus_a.round_reset), 1);
        $display("[TB] crash+survive: lives %0d level %0d", bus_a.lives, bus_a.level);

        // 4: last life lost -> OVER, events ignored, start restarts
        pulse_crash();
        check_eq("t4_state_hit", int'(bus_a.state), 2);
        check_eq("t4_lives", int'(bus_a.lives), 0);
        repeat (4) step();
        step();
        check_eq("t4_state_over", int'(bus_a.state), 4);
        check_eq("t4_game_over", int'(bus_a.game_over), 1);
        check_eq("t4_need_reset", int'(bus_a.need_reset), 1);
        bus_a.crashed  = 1'b1;
        bus_a.survived = 1'b1;
        measure(cyc, 4, a1, a2, na, b1, b2, nb);
        bus_a.crashed  = 1'b0;
        bus_a.survived = 1'b0;
        check_eq("t4_over_no_ticks", na, 0);
        check_eq("t4_over_holds", int'(bus_a.state), 4);
        check_eq("t4_over_lives", int'(bus_a.lives), 0);
        check_eq("t4_over_level", int'(bus_a.level), 1);
        pulse_start();
        check_eq("t4_restart_state", int'(bus_a.state), 1);
        check_eq("t4_restart_level", int'(bus_a.level), 0);
        check_eq("t4_restart_lives", int'(bus_a.lives), 2);
        check_eq("t4_restart_round_reset", int'(bus_a.round_reset), 1);
        check_eq("t4_restart_game_over", int'(bus_a.game_over), 0);
        $display("[TB] game over and restart checked at cycle %0d", cyc);

        // 5: three survives -> level 2 periods (6 vs floor 7), then WON
        pulse_survive();
        check_eq("t5_level1", int'(bus_a.level), 1);
        repeat (5) step();
        check_eq("t5_play1", int'(bus_a.state), 1);
        pulse_survive();
        check_eq("t5_level2", int'(bus_a.level), 2);
        repeat (5) step();
        r = cyc;
        check_eq("t5_play2", int'(bus_a.state), 1);
        check_eq("t5_round_reset2", int'(bus_a.round_reset), 1);
        measure(r, 20, a1, a2, na, b1, b2, nb);
        check_eq("t5_a_first_tick", a1, 5);
        check_eq("t5_a_spacing", a2 - a1, 6);
        check_eq("t5_b_first_tick", b1, 6);
        check_eq("t5_b_spacing", b2 - b1, 7);
        $display("[TB] level 2: spacing a=%0d b=%0d", a2 - a1, b2 - b1);
        pulse_survive();
        check_eq("t5_level3", int'(bus_a.level), 3);
        check_eq("t5_clear3", int'(bus_a.state), 3);
        repeat (4) step();
        check_eq("t5_still_clear3", int'(bus_a.state), 3);
        step();
        check_eq("t5_won", int'(bus_a.state), 5);
        check_eq("t5_won_game_over", int'(bus_a.game_over), 1);
        check_eq("t5_b_won", int'(bus_b.state), 5);
        pulse_start();
        check_eq("t5_won_restart", int'(bus_a.state), 1);
        check_eq("t5_won_restart_level", int'(bus_a.level), 0);
        $display("[TB] won and restart checked at cycle %0d", cyc);

        // 6: reset mid-pause in HIT together with start
        pulse_survive();
        repeat (5) step();
        check_eq("t6_play", int'(bus_a.state), 1);
        pulse_crash();
        check_eq("t6_hit", int'(bus_a.state), 2);
        repeat (2) step();
        reset       = 1'b1;
        bus_a.start = 1'b1;
        step();
        check_eq("t6_state", int'(bus_a.state), 0);
        check_eq("t6_level", int'(bus_a.level), 0);
        check_eq("t6_lives", int'(bus_a.lives), 2);
        check_eq("t6_car_tick", int'(bus_a.car_tick), 0);
        check_eq("t6_round_reset", int'(bus_a.round_reset), 0);
        check_eq("t6_need_reset", int'(bus_a.need_reset), 1);
        check_eq("t6_game_over", int'(bus_a.game_over), 0);
        bus_a.start = 1'b0;
        step();
        reset = 1'b0;
        step();
        check_eq("t6_idle_after", int'(bus_a.state), 0);
        $display("[TB] reset during pause checked at cycle %0d", cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
